fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Controls the instruction-fetch PC register from outside it. It drives the fetch stage's
//  stall, jump-enable and jump-address inputs and the IF/ID and ID/EX flush lines.
//  Arbitrates redirects from EX (branch) and ID (jump), load-use hazard stalls and
//  instruction-memory wait states. Adds a memory watchdog and a saturating stall counter.
// PARAMETERS
//  ADDR_W        20      PC / target address width
//  RESET_VECTOR  20'h0   PC value loaded during and after reset
//  TIMEOUT       16      max consecutive MEMWAIT cycles before fault (>=1)
//  COUNT_W       16      stall_count width
// PORTS
//  clock            in   1        single clock, all state on posedge
//  reset            in   1        synchronous, active-high
//  branch_taken     in   1        EX-stage branch resolved taken
//  branch_target    in   ADDR_W   EX-stage branch target
//  jump_valid       in   1        ID-stage unconditional jump
//  jump_target      in   ADDR_W   ID-stage jump target
//  hazard_stall     in   1        ID-stage load-use hazard
//  imem_ready       in   1        instruction at current PC returned this cycle
//  halt             in   1        halt request (decoded HALT instruction)
//  fetch_stall      out  1        freeze PC and IF/ID
//  fetch_jump_en    out  1        load PC from fetch_jump_addr at next edge
//  fetch_jump_addr  out  ADDR_W   redirect address
//  flush_if_id      out  1        invalidate IF/ID at next edge
//  flush_id_ex      out  1        insert bubble in ID/EX at next edge
//  imem_req         out  1        fetch request to instruction memory
//  mem_timeout      out  1        sticky watchdog fault
//  ctrl_state       out  3        BOOT=0 RUN=1 MEMWAIT=2 HALTED=3
//  stall_count      out  COUNT_W  cycles with fetch_stall=1, saturating
// BEHAVIOUR
//  Outputs are Mealy: they are combinational from state and inputs, so the PC acts at the same edge.
//  When no case below drives an output, it is 0. Redirects cost 0 extra cycles.
//  While reset=1: fetch_jump_en=1, fetch_jump_addr=RESET_VECTOR, fetch_stall=0,
//   both flushes=1, imem_req=0. At the edge: state<=BOOT, pending cleared,
//   mem_timeout<=0, stall_count<=0, watchdog<=0. Reset mid-operation discards everything.
//  BOOT (1 cycle): both flushes=1, imem_req=0, fetch_stall=1, next state RUN.
//  RUN: imem_req=1. The first matching rule below applies:
//   1 branch_taken & imem_ready: jump_en=1, addr=branch_target, both flushes=1.
//   2 jump_valid & imem_ready: jump_en=1, addr=jump_target, flush_if_id=1.
//   3 hazard_stall: fetch_stall=1, flush_id_ex=1. A branch/jump that arrives while
//     imem_ready=0 is handled as in rule 4.
//   4 imem_ready=0: fetch_stall=1, next state MEMWAIT. If a branch or jump is present,
//     capture it into pend_addr/pend_valid (branch wins). A branch also asserts flush_id_ex=1.
//   5 halt & imem_ready: fetch_stall=1, next state HALTED.
//   6 otherwise: normal sequential fetch, PC increments.
//  MEMWAIT: imem_req=1, fetch_stall=1. A new redirect overwrites pending only if it is a
//   branch, or if pending is empty. On imem_ready=1:
//   - pending set: jump_en=1, addr=pend_addr, flush_if_id=1, fetch_stall=0, pending cleared.
//   - pending clear: fetch_stall=0.
//   - then next state RUN.
//  Watchdog: counts consecutive MEMWAIT cycles without imem_ready. When the count reaches
//   TIMEOUT, set mem_timeout=1 and go to HALTED. It is cleared when MEMWAIT is left.
//  HALTED: fetch_stall=1, imem_req=0. All inputs are ignored. Only reset exits.
//  stall_count: increments each cycle fetch_stall=1 (BOOT and HALTED included).
//   It holds at 2^COUNT_W-1 and does not wrap.
//  fetch_jump_addr is RESET_VECTOR whenever fetch_jump_en=0.
// TESTING
//  T1 reset high for 2 cycles -> jump_en=1, addr=0x00000, imem_req=0. Then BOOT for 1 cycle, then
//     RUN with imem_req=1, fetch_stall=0, stall_count=1.
//  T2 RUN, imem_ready=1, branch_taken=1 to 0x00123 and jump_valid=1 to 0x00456 in the same cycle ->
//     jump_en=1, addr=0x00123, flush_if_id=1, flush_id_ex=1, no stall.
//  T3 RUN, hazard_stall=1 for 2 cycles -> fetch_stall=1 and flush_id_ex=1 for 2 cycles,
//     flush_if_id=0, stall_count +2.
//  T4 imem_ready=0 for 3 cycles, jump_valid to 0x00040 in cycle 2 -> MEMWAIT, stall for 3 cycles.
//     On ready: jump_en=1, addr=0x00040, flush_if_id=1, then back to RUN.
//  T5 TIMEOUT=8, imem_ready held 0 -> after 8 MEMWAIT cycles: mem_timeout=1, ctrl_state=3,
//     imem_req=0. Branch inputs are then ignored. Reset clears mem_timeout.
//  T6 COUNT_W=4, 20 stall cycles -> stall_count holds at 15. reset -> 0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Interface between the fetch sequencer and the surrounding pipeline.
// It carries the redirect sources, hazard, memory and halt inputs, plus all
// control outputs to the fetch stage and the pipeline registers.
//   master : the sequencer (drives fetch/flush/imem_req/status)
//   slave  : the pipeline / environment (drives redirects, hazard, imem_ready, halt)
// Handshake: imem_req is the request (valid) and imem_ready is the response
// (ready). A fetch completes in any cycle where both are 1. While imem_req=1
// and imem_ready=0 the PC is held, and the request stays asserted until
// imem_ready returns. imem_ready is ignored while imem_req=0.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 20,
  parameter int COUNT_W = 16
);
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_target;
  logic              hazard_stall;
  logic              imem_ready;
  logic              halt;
  logic              fetch_stall;
  logic              fetch_jump_en;
  logic [ADDR_W-1:0] fetch_jump_addr;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              imem_req;
  logic              mem_timeout;
  logic [2:0]        ctrl_state;
  logic [COUNT_W-1:0] stall_count;

  modport master (
    input  branch_taken, branch_target, jump_valid, jump_target,
           hazard_stall, imem_ready, halt,
    output fetch_stall, fetch_jump_en, fetch_jump_addr, flush_if_id,
           flush_id_ex, imem_req, mem_timeout, ctrl_state, stall_count
  );

  modport slave (
    output branch_taken, branch_target, jump_valid, jump_target,
           hazard_stall, imem_ready, halt,
    input  fetch_stall, fetch_jump_en, fetch_jump_addr, flush_if_id,
           flush_id_ex, imem_req, mem_timeout, ctrl_state, stall_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steers the external PC register through stall / jump-enable
// / jump-address, and drives the IF/ID and ID/EX flush lines. It arbitrates EX
// branches, ID jumps, load-use stalls and instruction-memory wait states. A
// watchdog faults the sequencer after TIMEOUT consecutive wait cycles, and a
// saturating counter records how many cycles the fetch was stalled.
// Ports:
//   clock  : single clock, all state on posedge
//   reset  : synchronous, active-high
//   bus    : fetch_sequencer_if.master (see the interface for the signal list)
// The control outputs are Mealy, so the PC reacts at the same edge.
// ctrl_state exposes the FSM state as BOOT=0 RUN=1 MEMWAIT=2 HALTED=3.
module fetch_sequencer #(
  parameter int                ADDR_W       = 20,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                TIMEOUT      = 16,
  parameter int                COUNT_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    RUN     = 3'd1,
    MEMWAIT = 3'd2,
    HALTED  = 3'd3
  } state_t;

  state_t             state_q, state_d;
  logic               pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               timeout_q, timeout_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               stall;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;
  logic               flush_ifid;
  logic               flush_idex;
  logic               req;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= BOOT;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= RESET_VECTOR;
      wd_q         <= '0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    wd_d         = '0;          // cleared in every cycle spent outside MEMWAIT
    timeout_d    = timeout_q;
    stall        = 1'b0;
    jump_en      = 1'b0;
    jump_addr    = RESET_VECTOR;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    req          = 1'b0;

    if (reset) begin
      // Load the reset vector into the PC and drain both pipeline registers.
      jump_en    = 1'b1;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else begin
      unique case (state_q)
        BOOT: begin
          stall      = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          state_d    = RUN;
        end

        RUN: begin
          req = 1'b1;
          if (bus.branch_taken && bus.imem_ready) begin
            jump_en    = 1'b1;
            jump_addr  = bus.branch_target;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (bus.jump_valid && bus.imem_ready) begin
            jump_en    = 1'b1;
            jump_addr  = bus.jump_target;
            flush_ifid = 1'b1;
          end else if (bus.hazard_stall &&
                       !(!bus.imem_ready && (bus.branch_taken || bus.jump_valid))) begin
            // A redirect that meets a memory wait must be captured, so the
            // load-use stall only wins when there is nothing to remember.
            stall      = 1'b1;
            flush_idex = 1'b1;
          end else if (!bus.imem_ready) begin
            stall   = 1'b1;
            state_d = MEMWAIT;
            if (bus.branch_taken) begin
              pend_valid_d = 1'b1;
              pend_addr_d  = bus.branch_target;
              flush_idex   = 1'b1;
            end else if (bus.jump_valid) begin
              pend_valid_d = 1'b1;
              pend_addr_d  = bus.jump_target;
            end
          end else if (bus.halt) begin
            stall   = 1'b1;
            state_d = HALTED;
          end
        end

        MEMWAIT: begin
          req   = 1'b1;
          stall = 1'b1;
          // EX branches are older than ID jumps, so a branch always replaces
          // a pending jump, and a jump never replaces anything.
          if (bus.branch_taken) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = bus.branch_target;
          end else if (bus.jump_valid && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = bus.jump_target;
          end
          if (bus.imem_ready) begin
            stall   = 1'b0;
            state_d = RUN;
            if (pend_valid_d) begin
              jump_en    = 1'b1;
              jump_addr  = pend_addr_d;
              flush_ifid = 1'b1;
            end
            pend_valid_d = 1'b0;
          end else begin
            wd_d = wd_q + 1'b1;
            if (wd_d == WD_W'(TIMEOUT)) begin
              timeout_d = 1'b1;
              state_d   = HALTED;
            end
          end
        end

        HALTED: begin
          stall = 1'b1;
        end

        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // Saturating stall counter; stall is 0 under reset and the register clears anyway.
  always_comb begin
    count_d = count_q;
    if (stall && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  assign bus.fetch_stall     = stall;
  assign bus.fetch_jump_en   = jump_en;
  assign bus.fetch_jump_addr = jump_addr;
  assign bus.flush_if_id     = flush_ifid;
  assign bus.flush_id_ex     = flush_idex;
  assign bus.imem_req        = req;
  assign bus.mem_timeout     = timeout_q;
  assign bus.ctrl_state      = state_q;
  assign bus.stall_count     = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int ADDR_W  = 20;
  localparam int COUNT_W = 4;
  localparam int CNT_MAX = 15;

  logic clock = 1'b0;
  logic reset;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  fetch_sequencer_if #(.ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) bus ();

  fetch_sequencer #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(20'h00000),
    .TIMEOUT     (8),
    .COUNT_W     (COUNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic br, input logic [19:0] bt, input logic jv,
                       input logic [19:0] jt, input logic hz, input logic rdy,
                       input logic hlt);
    bus.branch_taken  = br;
    bus.branch_target = bt;
    bus.jump_valid    = jv;
    bus.jump_target   = jt;
    bus.hazard_stall  = hz;
    bus.imem_ready    = rdy;
    bus.halt          = hlt;
  endtask

  // Check one cycle at the falling edge, then advance past the rising edge
  // and update the expected saturating stall count.
  task automatic cyc(input string tag, input logic regs, input logic st,
                     input logic jen, input logic [19:0] addr, input logic fif,
                     input logic fie, input logic req, input logic to,
                     input logic [2:0] state);
    @(negedge clock);
    chk({tag, ".stall"}, 32'(bus.fetch_stall), 32'(st));
    chk({tag, ".jump_en"}, 32'(bus.fetch_jump_en), 32'(jen));
    chk({tag, ".jump_addr"}, 32'(bus.fetch_jump_addr), 32'(addr));
    chk({tag, ".flush_if_id"}, 32'(bus.flush_if_id), 32'(fif));
    chk({tag, ".flush_id_ex"}, 32'(bus.flush_id_ex), 32'(fie));
    chk({tag, ".imem_req"}, 32'(bus.imem_req), 32'(req));
    if (regs) begin
      chk({tag, ".mem_timeout"}, 32'(bus.mem_timeout), 32'(to));
      chk({tag, ".ctrl_state"}, 32'(bus.ctrl_state), 32'(state));
      chk({tag, ".stall_count"}, 32'(bus.stall_count), 32'(exp_cnt));
    end
    @(posedge clock);
    if (reset) exp_cnt = 0;
    else if (st && exp_cnt < CNT_MAX) exp_cnt++;
    #1;
  endtask

  initial begin
    // T1: reset two cycles, BOOT, then RUN
    reset = 1'b1;
    drive(0, 20'h0, 0, 20'h0, 0, 1, 0);
    cyc("t1_rst0", 0, 0, 1, 20'h00000, 1, 1, 0, 0, 3'd0);
    cyc("t1_rst1", 1, 0, 1, 20'h00000, 1, 1, 0, 0, 3'd0);
    reset = 1'b0;
    cyc("t1_boot", 1, 1, 0, 20'h00000, 1, 1, 0, 0, 3'd0);
    cyc("t1_run",  1, 0, 0, 20'h00000, 0, 0, 1, 0, 3'd1);

    // T2: branch and jump together, branch wins; then a lone jump
    drive(1, 20'h00123, 1, 20'h00456, 0, 1, 0);
    cyc("t2_br",   1, 0, 1, 20'h00123, 1, 1, 1, 0, 3'd1);
    drive(0, 20'h0, 1, 20'h00200, 0, 1, 0);
    cyc("t2_jmp",  1, 0, 1, 20'h00200, 1, 0, 1, 0, 3'd1);

    // T3: load-use hazard for two cycles
    drive(0, 20'h0, 0, 20'h0, 1, 1, 0);
    cyc("t3_hz0",  1, 1, 0, 20'h00000, 0, 1, 1, 0, 3'd1);
    cyc("t3_hz1",  1, 1, 0, 20'h00000, 0, 1, 1, 0, 3'd1);
    drive(0, 20'h0, 0, 20'h0, 0, 1, 0);
    cyc("t3_run",  1, 0, 0, 20'h00000, 0, 0, 1, 0, 3'd1);

    // T4: three wait cycles, jump captured in cycle 2, replayed on ready
    drive(0, 20'h0, 0, 20'h0, 0, 0, 0);
    cyc("t4_w1",   1, 1, 0, 20'h00000, 0, 0, 1, 0, 3'd1);
    drive(0, 20'h0, 1, 20'h00040, 0, 0, 0);
    cyc("t4_w2",   1, 1, 0, 20'h00000, 0, 0, 1, 0, 3'd2);
    drive(0, 20'h0, 0, 20'h0, 0, 0, 0);
    cyc("t4_w3",   1, 1, 0, 20'h00000, 0, 0, 1, 0, 3'd2);
    drive(0, 20'h0, 0, 20'h0, 0, 1, 0);
    cyc("t4_rdy",  1, 0, 1, 20'h00040, 1, 0, 1, 0, 3'd2);
    cyc("t4_run",  1, 0, 0, 20'h00000, 0, 0, 1, 0, 3'd1);

    // Pending priority: jump captured, branch overwrites, later jump ignored
    drive(0, 20'h0, 1, 20'h00111, 0, 0, 0);
    cyc("pp_cap",  1, 1, 0, 20'h00000, 0, 0, 1, 0, 3'd1);
    drive(1, 20'h00222, 0, 20'h0, 0, 0, 0);
    cyc("pp_br",   1, 1, 0, 20'h00000, 0, 0, 1, 0, 3'd2);
    drive(0, 20'h0, 1, 20'h00333, 0, 0, 0);
    cyc("pp_jmp",  1, 1, 0, 20'h00000, 0, 0, 1, 0, 3'd2);
    drive(0, 20'h0, 0, 20'h0, 0, 1, 0);
    cyc("pp_rdy",  1, 0, 1, 20'h00222, 1, 0, 1, 0, 3'd2);
    cyc("pp_run",  1, 0, 0, 20'h00000, 0, 0, 1, 0, 3'd1);

    // Branch during a memory wait in RUN also bubbles ID/EX
    drive(1, 20'h000AA, 0, 20'h0, 0, 0, 0);
    cyc("bw_cap",  1, 1, 0, 20'h00000, 0, 1, 1, 0, 3'd1);
    drive(0, 20'h0, 0, 20'h0, 0, 1, 0);
    cyc("bw_rdy",  1, 0, 1, 20'h000AA, 1, 0, 1, 0, 3'd2);
    cyc("bw_run",  1, 0, 0, 20'h00000, 0, 0, 1, 0, 3'd1);

    // T5: watchdog after 8 MEMWAIT cycles; T6: stall_count saturates at 15
    drive(0, 20'h0, 0, 20'h0, 0, 0, 0);
    cyc("t5_enter", 1, 1, 0, 20'h00000, 0, 0, 1, 0, 3'd1);
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("t5_mw%0d", i), 1, 1, 0, 20'h00000, 0, 0, 1, 0, 3'd2);
    end
    cyc("t5_halt", 1, 1, 0, 20'h00000, 0, 0, 0, 1, 3'd3);
    drive(1, 20'h00777, 1, 20'h00888, 1, 1, 1);
    cyc("t5_ign0", 1, 1, 0, 20'h00000, 0, 0, 0, 1, 3'd3);
    cyc("t5_ign1", 1, 1, 0, 20'h00000, 0, 0, 0, 1, 3'd3);
    reset = 1'b1;
    drive(0, 20'h0, 0, 20'h0, 0, 1, 0);
    cyc("t5_rst",  1, 0, 1, 20'h00000, 1, 1, 0, 1, 3'd3);
    reset = 1'b0;
    cyc("t5_boot", 1, 1, 0, 20'h00000, 1, 1, 0, 0, 3'd0);
    cyc("t5_run",  1, 0, 0, 20'h00000, 0, 0, 1, 0, 3'd1);

    // Halt request while memory is ready
    drive(0, 20'h0, 0, 20'h0, 0, 1, 1);
    cyc("h_req",   1, 1, 0, 20'h00000, 0, 0, 1, 0, 3'd1);
    drive(0, 20'h0, 0, 20'h0, 0, 1, 0);
    cyc("h_halt",  1, 1, 0, 20'h00000, 0, 0, 0, 0, 3'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
